// File: rtl/clock_timekeeper_if.sv
// Control/display bundle between button_controller, clock_timekeeper and the display mux.
interface clock_timekeeper_if;
  logic [1:0] clk_mode;
  logic [3:0] vButton;
  logic       vAlarmActiveButton;
  logic [7:0] hh, mm, ss, dd, mo, al_hh, al_mm;
  logic       alarm_en, alarm_ring, sec_tick;

  modport master (
    output clk_mode, vButton, vAlarmActiveButton,
    input  hh, mm, ss, dd, mo, al_hh, al_mm, alarm_en, alarm_ring, sec_tick
  );
  modport slave (
    input  clk_mode, vButton, vAlarmActiveButton,
    output hh, mm, ss, dd, mo, al_hh, al_mm, alarm_en, alarm_ring, sec_tick
  );
endinterface

// File: rtl/clock_timekeeper.sv
// BCD time/date/alarm keeper with per-mode editing and alarm ringing.
// Optional snooze on vButton[0] while ringing: define ALARM_SNOOZE_EN.
module clock_timekeeper #(
  parameter int MFREQ_KHZ = 1
) (
  input logic         mclk,
  input logic         rst,
  clock_timekeeper_if.slave bus
);
  localparam int TICKS = MFREQ_KHZ * 1000;
  localparam int PW = $clog2(TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);

  logic [PW-1:0] presc, presc_n;
  logic [7:0] hh, mm, ss, dd, mo, al_hh, al_mm;
  logic [7:0] hh_n, mm_n, ss_n, dd_n, mo_n, al_hh_n, al_mm_n;
  logic [7:0] mlen_cur, mlen_new;
  logic       alarm_en, alarm_en_n, alarm_ring, ring_n, sec_tick;
  logic [5:0] ring_cnt, ring_cnt_n;
  logic       tick, trigger, en_clear, btn_dismiss, dismiss;
`ifdef ALARM_SNOOZE_EN
  logic       snooze_on, snooze_on_n;
  logic [8:0] snooze_cnt, snooze_cnt_n;
`endif

  // BCD increment that wraps from last back to first.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] last,
                                          input logic [7:0] first);
    if (v == last) return first;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] m);
    case (m)
      8'h02:                      return 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Digit-wise HH:MM edit; the lowest set button bit wins.
  function automatic logic [15:0] edit_hm(input logic [7:0] h, input logic [7:0] m,
                                          input logic [3:0] btn);
    logic [7:0] nh, nm;
    nh = h;
    nm = m;
    if (btn[0])      nm[3:0] = (m[3:0] == 4'd9) ? 4'd0 : m[3:0] + 4'd1;
    else if (btn[1]) nm[7:4] = (m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1;
    else if (btn[2]) nh[3:0] = ((h[7:4] == 4'd2 && h[3:0] == 4'd3) || h[3:0] == 4'd9) ?
                               4'd0 : h[3:0] + 4'd1;
    else if (btn[3]) begin
      case (h[7:4])
        4'd0:    nh[7:4] = 4'd1;
        4'd1: begin
          nh[7:4] = 4'd2;
          if (h[3:0] > 4'd3) nh[3:0] = 4'd3;
        end
        default: nh[7:4] = 4'd0;
      endcase
    end
    return {nh, nm};
  endfunction

  always_comb begin
    tick     = (bus.clk_mode != 2'd1) && (presc == PRESC_LAST);
    presc_n  = (bus.clk_mode == 2'd1 || tick) ? '0 : presc + 1'b1;
    hh_n     = hh;
    mm_n     = mm;
    ss_n     = ss;
    dd_n     = dd;
    mo_n     = mo;
    al_hh_n  = al_hh;
    al_mm_n  = al_mm;
    mlen_cur = month_len(mo);
    mlen_new = mlen_cur;

    if (bus.clk_mode == 2'd1) ss_n = 8'h00;
    else if (tick) begin
      ss_n = bcd_step(ss, 8'h59, 8'h00);
      if (ss == 8'h59) begin
        mm_n = bcd_step(mm, 8'h59, 8'h00);
        if (mm == 8'h59) begin
          hh_n = bcd_step(hh, 8'h23, 8'h00);
          if (hh == 8'h23) begin
            dd_n = bcd_step(dd, mlen_cur, 8'h01);
            if (dd == mlen_cur) mo_n = bcd_step(mo, 8'h12, 8'h01);
          end
        end
      end
    end

    // Edits override whatever the carry chain produced for the same fields.
    case (bus.clk_mode)
      2'd1: if (|bus.vButton) {hh_n, mm_n} = edit_hm(hh, mm, bus.vButton);
      2'd2: if (|bus.vButton) {al_hh_n, al_mm_n} = edit_hm(al_hh, al_mm, bus.vButton);
      2'd3: begin
        if (bus.vButton[0]) begin
          dd_n = bcd_step(dd, mlen_cur, 8'h01);
          mo_n = mo;
        end else if (bus.vButton[1]) begin
          mo_n     = bcd_step(mo, 8'h12, 8'h01);
          mlen_new = month_len(mo_n);
          dd_n     = (dd > mlen_new) ? mlen_new : dd;
        end
      end
      default: ;
    endcase

    alarm_en_n  = alarm_en ^ bus.vAlarmActiveButton;
    en_clear    = alarm_en && bus.vAlarmActiveButton;
    btn_dismiss = (bus.clk_mode == 2'd0) && (|bus.vButton);
    trigger     = alarm_en && (bus.clk_mode == 2'd0) && sec_tick &&
                  hh == al_hh && mm == al_mm && ss == 8'h00;
    dismiss     = (bus.clk_mode != 2'd0) || btn_dismiss || en_clear ||
                  (alarm_ring && sec_tick && ring_cnt == 6'd59);
    ring_cnt_n  = !alarm_ring ? 6'd0 : (sec_tick ? ring_cnt + 6'd1 : ring_cnt);
    ring_n      = dismiss ? 1'b0 : (trigger ? 1'b1 : alarm_ring);
`ifdef ALARM_SNOOZE_EN
    snooze_on_n  = snooze_on;
    snooze_cnt_n = snooze_cnt;
    if (alarm_ring && btn_dismiss && bus.vButton[0]) begin
      snooze_on_n  = 1'b1;
      snooze_cnt_n = 9'd300;
    end else if (snooze_on) begin
      if (bus.clk_mode != 2'd0 || btn_dismiss || en_clear) snooze_on_n = 1'b0;
      else if (sec_tick) begin
        if (snooze_cnt == 9'd1) begin
          snooze_on_n  = 1'b0;
          snooze_cnt_n = 9'd0;
          ring_n       = 1'b1;
        end else snooze_cnt_n = snooze_cnt - 9'd1;
      end
    end
`endif
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      presc      <= '0;
      hh         <= 8'h00;
      mm         <= 8'h00;
      ss         <= 8'h00;
      dd         <= 8'h01;
      mo         <= 8'h01;
      al_hh      <= 8'h00;
      al_mm      <= 8'h00;
      alarm_en   <= 1'b0;
      alarm_ring <= 1'b0;
      ring_cnt   <= 6'd0;
      sec_tick   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_on  <= 1'b0;
      snooze_cnt <= 9'd0;
`endif
    end else begin
      presc      <= presc_n;
      hh         <= hh_n;
      mm         <= mm_n;
      ss         <= ss_n;
      dd         <= dd_n;
      mo         <= mo_n;
      al_hh      <= al_hh_n;
      al_mm      <= al_mm_n;
      alarm_en   <= alarm_en_n;
      alarm_ring <= ring_n;
      ring_cnt   <= ring_cnt_n;
      sec_tick   <= tick;
`ifdef ALARM_SNOOZE_EN
      snooze_on  <= snooze_on_n;
      snooze_cnt <= snooze_cnt_n;
`endif
    end
  end

  assign bus.hh         = hh;
  assign bus.mm         = mm;
  assign bus.ss         = ss;
  assign bus.dd         = dd;
  assign bus.mo         = mo;
  assign bus.al_hh      = al_hh;
  assign bus.al_mm      = al_mm;
  assign bus.alarm_en   = alarm_en;
  assign bus.alarm_ring = alarm_ring;
  assign bus.sec_tick   = sec_tick;
endmodule
